// File: rtl/semafor_pkg.sv
// ----------------------------------------------------------------------------
// semafor_pkg
// Shared definitions for the traffic-light controller:
//   - phase_e : 3-bit phase code, also the visible stare_semafor value
//   - dir_e   : green direction that follows a pedestrian walk
//   - default phase durations (in en-high cycles) and timer width
// ----------------------------------------------------------------------------
package semafor_pkg;

  typedef enum logic [2:0] {
    ALL_RED_A   = 3'b000,
    NS_GREEN    = 3'b001,
    NS_YELLOW   = 3'b010,
    ALL_RED_B   = 3'b011,
    EW_GREEN    = 3'b100,
    EW_YELLOW   = 3'b101,
    PED_WALK    = 3'b110,
    NIGHT_BLINK = 3'b111
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam int unsigned T_GREEN_DEF  = 20;
  localparam int unsigned T_YELLOW_DEF = 3;
  localparam int unsigned T_ALLRED_DEF = 2;
  localparam int unsigned T_PED_DEF    = 10;
  localparam int unsigned T_BLINK_DEF  = 5;
  localparam int unsigned CNT_W_DEF    = 11;

endpackage

// File: rtl/semafor_if.sv
// ----------------------------------------------------------------------------
// semafor_if
// Groups the controller's request inputs and light outputs.
//   en            : timer advance enable (low freezes state and timer)
//   ped_req       : pedestrian request, level or pulse
//   night         : night-mode request level
//   stare_semafor : registered phase code (this is the FSM state itself)
//   ped_ack       : one-cycle pulse on entry to the walk phase
//   blink         : registered yellow-flash drive
// Signalling: there is no valid/ready handshake; every input is a level
// sampled on each rising clock edge and every output is a registered level.
// Modports: master drives the requests (environment), slave is the
// controller.
// ----------------------------------------------------------------------------
interface semafor_if;
  logic       en;
  logic       ped_req;
  logic       night;
  logic [2:0] stare_semafor;
  logic       ped_ack;
  logic       blink;

  modport master (
    output en, ped_req, night,
    input  stare_semafor, ped_ack, blink
  );

  modport slave (
    input  en, ped_req, night,
    output stare_semafor, ped_ack, blink
  );
endinterface

// File: rtl/semafor_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Down-counter that times the current phase.
//   clk, rst : clock, asynchronous active-low reset (count := RST_VAL)
//   load     : load load_val (takes priority over counting)
//   load_val : T-1 of the phase being entered
//   en       : decrement enable; counter saturates at zero
//   zero     : counter is zero (last cycle of the phase)
// ----------------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned     CNT_W   = 11,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/semafor_ctrl.sv
// ----------------------------------------------------------------------------
// semafor_ctrl
// Traffic-light phase controller with pedestrian walk insertion and an
// optional night (yellow-flash) mode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : semafor_if.slave (en, ped_req, night in; stare_semafor, ped_ack,
//          blink out)
// Optional feature: NIGHT_MODE_EN enables the NIGHT_BLINK phase. Without it
// the night input is ignored and blink is tied low.
// ----------------------------------------------------------------------------
module semafor_ctrl
  import semafor_pkg::*;
#(
  parameter int unsigned T_GREEN  = T_GREEN_DEF,
  parameter int unsigned T_YELLOW = T_YELLOW_DEF,
  parameter int unsigned T_ALLRED = T_ALLRED_DEF,
  parameter int unsigned T_PED    = T_PED_DEF,
  parameter int unsigned T_BLINK  = T_BLINK_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  semafor_if.slave bus
);

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(T_BLINK - 1);

  phase_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic             pend_q;
  logic             ack_q;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             zero;
  logic             night_now;

`ifdef NIGHT_MODE_EN
  assign night_now = bus.night;
`else
  assign night_now = 1'b0;
`endif

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALLRED)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (bus.en),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ALL_RED_A;
      dir_q   <= DIR_NS;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      // Only transitions load the timer, so this is high for exactly the
      // first cycle of a walk.
      ack_q   <= load && (state_d == PED_WALK);
    end
  end

  // A request during the walk (including the ack cycle) is absorbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
    end else if (state_q == PED_WALK) begin
      pend_q <= 1'b0;
    end else if (bus.ped_req) begin
      pend_q <= 1'b1;
    end
  end

  // Next-state: phases only change on the last en-high cycle of a phase.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    load    = 1'b0;
    if (bus.en && zero) begin
      load = 1'b1;
      case (state_q)
        ALL_RED_A: begin
          if (night_now) begin
            state_d = NIGHT_BLINK;
          end else if (pend_q) begin
            state_d = PED_WALK;
            dir_d   = DIR_NS;
          end else begin
            state_d = NS_GREEN;
          end
        end
        NS_GREEN:  state_d = NS_YELLOW;
        NS_YELLOW: state_d = ALL_RED_B;
        ALL_RED_B: begin
          if (night_now) begin
            state_d = NIGHT_BLINK;
          end else if (pend_q) begin
            state_d = PED_WALK;
            dir_d   = DIR_EW;
          end else begin
            state_d = EW_GREEN;
          end
        end
        EW_GREEN:  state_d = EW_YELLOW;
        EW_YELLOW: state_d = ALL_RED_A;
        PED_WALK:  state_d = (dir_q == DIR_NS) ? NS_GREEN : EW_GREEN;
        // Each half-period boundary samples night; staying reloads the timer.
        NIGHT_BLINK: state_d = night_now ? NIGHT_BLINK : ALL_RED_A;
        default:   state_d = ALL_RED_A;
      endcase
    end
  end

  always_comb begin
    load_val = LD_ALLRED;
    case (state_d)
      NS_GREEN, EW_GREEN:   load_val = LD_GREEN;
      NS_YELLOW, EW_YELLOW: load_val = LD_YELLOW;
      PED_WALK:             load_val = LD_PED;
      NIGHT_BLINK:          load_val = LD_BLINK;
      default:              load_val = LD_ALLRED;
    endcase
  end

`ifdef NIGHT_MODE_EN
  logic blink_q;

  // Starts at 1 on entry, toggles at every half-period reload, 0 on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= 1'b0;
    end else if (load) begin
      if (state_d == NIGHT_BLINK) begin
        blink_q <= (state_q == NIGHT_BLINK) ? ~blink_q : 1'b1;
      end else begin
        blink_q <= 1'b0;
      end
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.stare_semafor = state_q;
  assign bus.ped_ack       = ack_q;

endmodule

// File: tb/tb_semafor_ctrl.sv
// ----------------------------------------------------------------------------
// tb_semafor_ctrl
// Directed table-driven bench for semafor_ctrl with short phase durations
// (T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_PED=3, T_BLINK=2). Each table row
// is the input applied before one rising edge and the outputs expected
// right after it. Expectations for night mode follow NIGHT_MODE_EN.
// ----------------------------------------------------------------------------
module tb_semafor_ctrl;

  logic clk;
  logic rst;

  semafor_if bus();

  semafor_ctrl #(
    .T_GREEN  (4),
    .T_YELLOW (2),
    .T_ALLRED (1),
    .T_PED    (3),
    .T_BLINK  (2),
    .CNT_W    (11)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    int         scn;
    logic       en;
    logic       ped;
    logic       night;
    logic [2:0] code;
    logic       ack;
    logic       blink;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  task automatic add_run(input int scn, input int n, input logic en,
                         input logic ped, input logic night,
                         input logic [2:0] code, input logic ack,
                         input logic blink);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.scn = scn; v.en = en; v.ped = ped; v.night = night;
      v.code = code; v.ack = ack; v.blink = blink;
      tbl.push_back(v);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string name, input int idx,
                           input logic [2:0] act, input logic [2:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_reset(input string name);
    check_val({name, " code"}, 0, bus.stare_semafor, 3'd0);
    check_val({name, " ack"}, 0, {2'b0, bus.ped_ack}, 3'd0);
    check_val({name, " blink"}, 0, {2'b0, bus.blink}, 3'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    bus.en = 1'b1; bus.ped_req = 1'b0; bus.night = 1'b0;
    rst = 1'b0;
    #1;
    check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_scn(input int id, input string name);
    logic [4:0] e;
    int         row;
    row = 0;
    foreach (tbl[i]) begin
      if (tbl[i].scn == id) begin
        bus.en      = tbl[i].en;
        bus.ped_req = tbl[i].ped;
        bus.night   = tbl[i].night;
        exp_q.push_back({tbl[i].code, tbl[i].ack, tbl[i].blink});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({name, " code"}, row, bus.stare_semafor, e[4:2]);
        check_val({name, " ack"}, row, {2'b0, bus.ped_ack}, {2'b0, e[1]});
        check_val({name, " blink"}, row, {2'b0, bus.blink}, {2'b0, e[0]});
        row++;
      end
    end
  endtask

  // ---------------- test ----------------
  logic [2:0] base_seq [14];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.en = 1'b1; bus.ped_req = 1'b0; bus.night = 1'b0;
    base_seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd0};

    // 0: free-running base cycle, two full periods
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 14; i++)
        add_run(0, 1, 1'b1, 1'b0, 1'b0, base_seq[i], 1'b0, 1'b0);

    // 1: one-cycle ped pulse during NS_GREEN
    add_run(1, 1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(1, 1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(1, 2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(1, 2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add_run(1, 1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add_run(1, 1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
    add_run(1, 2, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0);
    add_run(1, 4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
    add_run(1, 2, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);
    add_run(1, 1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add_run(1, 1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);

    // 2: ped_req held high -> walk after every all-red, one ack each
    add_run(2, 4, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
    add_run(2, 4, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
    add_run(2, 4, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    add_run(2, 2, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);
    add_run(2, 1, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);

    // 3: en low for 5 cycles mid NS_GREEN stretches it by 5
    add_run(3, 2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(3, 5, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(3, 2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(3, 2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
    add_run(3, 1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add_run(3, 1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);

    // 4: night raised during EW_GREEN, dropped later
    for (int i = 0; i < 8; i++)
      add_run(4, 1, 1'b1, 1'b0, 1'b0, base_seq[i], 1'b0, 1'b0);
    add_run(4, 3, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
    add_run(4, 2, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0);
    add_run(4, 1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
`ifdef NIGHT_MODE_EN
    add_run(4, 2, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    add_run(4, 2, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    add_run(4, 2, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    add_run(4, 1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    add_run(4, 1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
`else
    add_run(4, 4, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    add_run(4, 2, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    add_run(4, 1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0);
    add_run(4, 1, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
`endif

    // 5: ped request latched, run into NS_YELLOW (then reset mid-phase)
    add_run(5, 1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(5, 1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(5, 2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
    add_run(5, 1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);

    do_reset();
    run_scn(0, "base");
    do_reset();
    run_scn(1, "ped_pulse");
    do_reset();
    run_scn(2, "ped_hold");
    do_reset();
    run_scn(3, "en_hold");
    do_reset();
    run_scn(4, "night");
    do_reset();
    run_scn(5, "pre_rst");

    // Asynchronous reset in the middle of NS_YELLOW with a pending walk
    bus.ped_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    run_scn(0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
